// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_responder_pkg
// Shared definitions for the instruction-memory responder:
//   - FSM state encodings (IMEM_S_IDLE .. IMEM_S_RESP)
//   - beat-to-slot mapping of 16-bit SRAM halfwords into the 64-bit word
// No ports; imported by imem_responder and imem_wait_counter.
// -----------------------------------------------------------------------------
package imem_responder_pkg;

    localparam logic [2:0] IMEM_S_IDLE    = 3'd0;
    localparam logic [2:0] IMEM_S_ISSUE   = 3'd1;
    localparam logic [2:0] IMEM_S_WAIT    = 3'd2;
    localparam logic [2:0] IMEM_S_CAPTURE = 3'd3;
    localparam logic [2:0] IMEM_S_RESP    = 3'd4;

    localparam logic [1:0] IMEM_LAST_BEAT = 2'd3;

    // Beat 0 is the most significant halfword, beat 3 the least significant.
    function automatic logic [63:0] slot_insert(input logic [63:0] word,
                                                input logic [1:0]  beat,
                                                input logic [15:0] hw);
        logic [63:0] res;
        res = word;
        case (beat)
            2'd0:    res[63:48] = hw;
            2'd1:    res[47:32] = hw;
            2'd2:    res[31:16] = hw;
            2'd3:    res[15:0]  = hw;
            default: res        = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_wait_counter.sv
// -----------------------------------------------------------------------------
// imem_wait_counter
// Loadable 4-bit down-counter with zero flag; times the SRAM wait states.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val this cycle (takes priority over decrement)
//   load_val in   4-bit value to load
//   zero     out  count register equals zero
// The counter saturates at zero rather than wrapping.
// -----------------------------------------------------------------------------
module imem_wait_counter
    import imem_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] count_r;

    // Down-counter: load has priority, otherwise decrement until zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Responder end of the fetch instruction-memory bus. A request latches a word
// address, four halfwords are read from a synchronous SRAM with WAIT_STATES
// extra cycles each, assembled MSB-first and returned with a one-cycle
// imem_data_valid pulse. Requests may be aborted (valid drops) or redirected
// (word address changes) while a fill is in flight.
//
// Optional build macro IMEM_LINEBUF_EN: keeps a tag of the last completed word
// so a repeat request completes in one cycle without touching the SRAM;
// imem_flush invalidates it. Without the macro imem_flush is ignored.
//
// Parameters: ADDR_W (SRAM halfword address width), WAIT_STATES (0..15)
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   imem_addr        byte address; only bits [ADDR_W:3] select the word
//   imem_addr_valid  request, held with imem_addr until imem_data_valid
//   imem_data        assembled 64-bit word, changes only on a response
//   imem_data_valid  one-cycle response pulse
//   imem_flush       line-buffer invalidate
//   mem_addr         SRAM halfword address {word, beat}
//   mem_rd_en        SRAM read strobe, one cycle per beat
//   mem_rdata        SRAM read data
// -----------------------------------------------------------------------------
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       imem_addr,
    input  logic              imem_addr_valid,
    output logic [63:0]       imem_data,
    output logic              imem_data_valid,
    input  logic              imem_flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rdata
);

    // Word address is ADDR_W-2 bits so that {word, beat} fills mem_addr exactly.
    localparam int         WORD_W    = ADDR_W - 2;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]        state_r, state_s;
    logic [1:0]        beat_r, beat_s;
    logic [WORD_W-1:0] word_r, word_s, req_word_s;
    logic [63:0]       asm_r, data_r;
    logic              valid_r, rd_en_r;
    logic [ADDR_W-1:0] maddr_r;
    logic              cap_s, hit_s, wait_zero_s;
    logic              unused_s;

    assign req_word_s = imem_addr[ADDR_W:3];
    assign unused_s   = ^{imem_addr[63:ADDR_W+1], imem_addr[2:0], imem_flush};

    imem_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_r == IMEM_S_ISSUE),
        .load_val (WAIT_LOAD),
        .zero     (wait_zero_s)
    );

`ifdef IMEM_LINEBUF_EN
    logic [WORD_W-1:0] lb_tag_r;
    logic              lb_valid_r;

    // Line-buffer tag: flush wins; otherwise every response records its word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_tag_r   <= '0;
            lb_valid_r <= 1'b0;
        end else if (imem_flush) begin
            lb_tag_r   <= lb_tag_r;
            lb_valid_r <= 1'b0;
        end else if (state_r == IMEM_S_RESP) begin
            lb_tag_r   <= word_r;
            lb_valid_r <= 1'b1;
        end else begin
            lb_tag_r   <= lb_tag_r;
            lb_valid_r <= lb_valid_r;
        end
    end

    // A flush in the request cycle forces a miss. On a hit imem_data already
    // holds the tagged word, since it was the last response delivered.
    assign hit_s = lb_valid_r && !imem_flush && (req_word_s == lb_tag_r);
`else
    assign hit_s = 1'b0;
`endif

    // Next-state logic, including abort and redirect during a fill.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        word_s  = word_r;
        cap_s   = 1'b0;
        case (state_r)
            IMEM_S_IDLE: begin
                if (imem_addr_valid) begin
                    word_s = req_word_s;
                    beat_s = 2'd0;
                    if (hit_s) begin
                        state_s = IMEM_S_RESP;
                    end else begin
                        state_s = IMEM_S_ISSUE;
                    end
                end else begin
                    state_s = IMEM_S_IDLE;
                end
            end
            IMEM_S_ISSUE, IMEM_S_WAIT, IMEM_S_CAPTURE: begin
                if (!imem_addr_valid) begin
                    state_s = IMEM_S_IDLE;
                end else if (req_word_s != word_r) begin
                    word_s  = req_word_s;
                    beat_s  = 2'd0;
                    state_s = IMEM_S_ISSUE;
                end else if (state_r == IMEM_S_ISSUE) begin
                    if (WAIT_STATES == 0) begin
                        state_s = IMEM_S_CAPTURE;
                    end else begin
                        state_s = IMEM_S_WAIT;
                    end
                end else if (state_r == IMEM_S_WAIT) begin
                    if (wait_zero_s) begin
                        state_s = IMEM_S_CAPTURE;
                    end else begin
                        state_s = IMEM_S_WAIT;
                    end
                end else begin
                    cap_s = 1'b1;
                    if (beat_r == IMEM_LAST_BEAT) begin
                        state_s = IMEM_S_RESP;
                    end else begin
                        beat_s  = beat_r + 2'd1;
                        state_s = IMEM_S_ISSUE;
                    end
                end
            end
            IMEM_S_RESP: begin
                state_s = IMEM_S_IDLE;
            end
            default: begin
                state_s = IMEM_S_IDLE;
            end
        endcase
    end

    // State, SRAM strobe/address, assembly register and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IMEM_S_IDLE;
            beat_r  <= 2'd0;
            word_r  <= '0;
            rd_en_r <= 1'b0;
            maddr_r <= '0;
            asm_r   <= 64'd0;
            valid_r <= 1'b0;
            data_r  <= 64'd0;
        end else begin
            state_r <= state_s;
            beat_r  <= beat_s;
            word_r  <= word_s;
            // Strobe is high exactly for the ISSUE cycle of each beat.
            rd_en_r <= (state_s == IMEM_S_ISSUE);
            if (state_s == IMEM_S_ISSUE) begin
                maddr_r <= {word_s, beat_s};
            end else begin
                maddr_r <= maddr_r;
            end
            if (cap_s) begin
                asm_r <= slot_insert(asm_r, beat_r, mem_rdata);
            end else begin
                asm_r <= asm_r;
            end
            valid_r <= (state_s == IMEM_S_RESP);
            // The last beat goes straight into the output word so no
            // partially assembled value is ever visible on imem_data.
            if (cap_s && (state_s == IMEM_S_RESP)) begin
                data_r <= slot_insert(asm_r, beat_r, mem_rdata);
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign imem_data       = data_r;
    assign imem_data_valid = valid_r;
    assign mem_addr        = maddr_r;
    assign mem_rd_en       = rd_en_r;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Self-checking bench for imem_responder. Two instances: u_dut (WAIT_STATES=1)
// and u_dut0 (WAIT_STATES=0). Each has an SRAM model returning the halfword
// address as data WAIT_STATES+1 cycles after the read strobe. Expected words
// and response cycles come from address arithmetic and the latency rule
// 1 + 4*(WAIT_STATES+2) counted from the cycle a request (or redirect) is seen.
// Honours IMEM_LINEBUF_EN when defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_responder;

    localparam int LAT = 13;
`ifdef IMEM_LINEBUF_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_RDS = 0;
`else
    localparam int HIT_LAT = 13;
    localparam int HIT_RDS = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic [63:0] imem_addr;
    logic        imem_addr_valid;
    logic        valid0;
    logic        imem_flush;

    logic [63:0] imem_data, data0;
    logic        imem_data_valid, dv0;
    logic [15:0] mem_addr, ma0;
    logic        mem_rd_en, re0;
    logic [15:0] mem_rdata, rd0;

    logic        st_v;
    logic [15:0] st_a;
    logic [15:0] rd_q[$];

    int total = 0;
    int bad   = 0;

    imem_responder #(.ADDR_W(16), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid),
        .imem_data(imem_data), .imem_data_valid(imem_data_valid), .imem_flush(imem_flush),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    imem_responder #(.ADDR_W(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_addr_valid(valid0),
        .imem_data(data0), .imem_data_valid(dv0), .imem_flush(imem_flush),
        .mem_addr(ma0), .mem_rd_en(re0), .mem_rdata(rd0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM with one wait state: data appears two cycles after the strobe cycle.
    always @(posedge clk) begin
        st_v <= mem_rd_en;
        st_a <= mem_addr;
        if (st_v) mem_rdata <= st_a;
    end

    // SRAM with no wait states: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (re0) rd0 <= ma0;
    end

    // Record every read address issued by u_dut.
    always @(negedge clk) begin
        if (mem_rd_en) rd_q.push_back(mem_addr);
    end

    function automatic logic [63:0] exp_word(input logic [63:0] a);
        logic [15:0] h;
        h = {a[16:3], 2'b00};
        return {h, h + 16'd1, h + 16'd2, h + 16'd3};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Start a request from an IDLE cycle; optionally move to a1 during cycle k.
    // Returns the cycle of the response pulse, or -1 if none within maxc.
    task automatic fetch(input logic [63:0] a0, input int k, input logic [63:0] a1,
                         input int maxc, output int cyc);
        imem_addr       = a0;
        imem_addr_valid = 1'b1;
        cyc             = -1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (imem_data_valid) begin
                cyc = c;
                break;
            end
            if (c == k) imem_addr = a1;
        end
    endtask

    task automatic go_idle();
        imem_addr_valid = 1'b0;
        tick();
    endtask

    initial begin
        int          cyc;
        int          pulses;
        int          k;
        logic [63:0] a0, a1;

        rst_n = 1'b0; imem_addr = 64'd0; imem_addr_valid = 1'b0; valid0 = 1'b0;
        imem_flush = 1'b1; mem_rdata = 16'd0; rd0 = 16'd0; st_v = 1'b0; st_a = 16'd0;
        tick(); tick();
        chk("rst_data", imem_data, 64'd0);
        chk("rst_valid", {63'd0, imem_data_valid}, 64'd0);
        chk("rst_rden", {63'd0, mem_rd_en}, 64'd0);
        chk("rst_maddr", {48'd0, mem_addr}, 64'd0);
        chk("rst_data0", data0, 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: single read, one wait state.
        rd_q.delete();
        fetch(64'h40, 0, 64'h0, 30, cyc);
        chk("t1_cycle", 64'(cyc), 64'd13);
        chk("t1_data", imem_data, 64'h0020_0021_0022_0023);
        chk("t1_nrd", 64'(rd_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_maddr", {48'd0, rd_q[i]}, 64'h20 + 64'(i));
        go_idle();
        chk("t1_pulse_width", {63'd0, imem_data_valid}, 64'd0);

        // 2: zero wait states on the second instance.
        imem_addr = 64'h08;
        valid0    = 1'b1;
        cyc       = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (dv0) begin
                cyc = c;
                break;
            end
        end
        valid0 = 1'b0;
        chk("t2_cycle", 64'(cyc), 64'd9);
        chk("t2_data", data0, 64'h0004_0005_0006_0007);
        tick();

        // 3: abort during beat 2 (cycle 8 is its wait cycle).
        fetch(64'h100, 0, 64'h0, 8, cyc);
        imem_addr_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (imem_data_valid) pulses++;
        end
        chk("t3_pulses", 64'(pulses), 64'd0);
        chk("t3_data_kept", imem_data, 64'h0020_0021_0022_0023);

        // 4: redirect 0x40 -> 0x80 during beat 1.
        fetch(64'h40, 5, 64'h80, 40, cyc);
        chk("t4_cycle", 64'(cyc), 64'd18);
        chk("t4_data", imem_data, 64'h0040_0041_0042_0043);
        go_idle();

        // 5: back-to-back with valid held high.
        fetch(64'h00, 0, 64'h0, 30, cyc);
        chk("t5a_cycle", 64'(cyc), 64'd13);
        chk("t5a_data", imem_data, 64'h0000_0001_0002_0003);
        fetch(64'h08, 0, 64'h0, 30, cyc);
        chk("t5b_gap", 64'(cyc), 64'd14);
        chk("t5b_data", imem_data, 64'h0004_0005_0006_0007);
        go_idle();

        // Random requests, some redirected mid-fill (flush held: all misses).
        for (int i = 0; i < 20; i++) begin
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            if (a1[16:3] == a0[16:3]) a1[3] = ~a1[3];
            k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
            fetch(a0, k, a1, 40, cyc);
            chk("rnd_cycle", 64'(cyc), (k > 0) ? 64'(k + LAT) : 64'(LAT));
            chk("rnd_data", imem_data, exp_word((k > 0) ? a1 : a0));
            go_idle();
            repeat ($urandom_range(0, 2)) tick();
        end

        // 6: repeat request (line buffer hit when enabled), then flush.
        imem_flush = 1'b0;
        tick();
        fetch(64'h40, 0, 64'h0, 30, cyc);
        chk("t6_fill_cycle", 64'(cyc), 64'd13);
        go_idle();
        rd_q.delete();
        fetch(64'h40, 0, 64'h0, 30, cyc);
        chk("t6_hit_cycle", 64'(cyc), 64'(HIT_LAT));
        chk("t6_hit_data", imem_data, 64'h0020_0021_0022_0023);
        chk("t6_hit_rds", 64'(rd_q.size()), 64'(HIT_RDS));
        go_idle();
        imem_flush = 1'b1;
        tick();
        imem_flush = 1'b0;
        fetch(64'h40, 0, 64'h0, 30, cyc);
        chk("t6_flush_cycle", 64'(cyc), 64'd13);
        go_idle();

        // Asynchronous reset in the middle of a fill.
        fetch(64'h200, 0, 64'h0, 6, cyc);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_data", imem_data, 64'd0);
        chk("arst_valid", {63'd0, imem_data_valid}, 64'd0);
        chk("arst_rden", {63'd0, mem_rd_en}, 64'd0);
        chk("arst_maddr", {48'd0, mem_addr}, 64'd0);
        imem_addr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        // Reset also clears the line buffer, so this is a full fill.
        fetch(64'h40, 0, 64'h0, 30, cyc);
        chk("post_rst_cycle", 64'(cyc), 64'd13);
        chk("post_rst_data", imem_data, 64'h0020_0021_0022_0023);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
